// File: rtl/rv32_fetch_queue.sv
// rv32 fetch stage: owns the word-addressed PC, issues 1-cycle-latency imem requests
// and buffers returned instructions with their PC in a DEPTH-entry queue towards decode.
module rv32_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     IADDR_W  = 10,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    halt,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    imem_req,
  output logic [IADDR_W-1:0]      imem_addr,
  input  logic [31:0]             imem_rdata,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [31:0]             inst,
  output logic [XLEN-1:0]         inst_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     inst_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q   [DEPTH];

  logic            flush_c, issue_c, push_c, pop_c;
  logic [OW-1:0]   occupancy_c;

  // Credit check counts the in-flight word so a return can never find the queue full.
  always_comb begin
    flush_c     = redirect_valid & (state_q != BOOT);
    occupancy_c = OW'(count_q) + OW'(inflight_q);
    issue_c     = (state_q == RUN) & ~halt & ~redirect_valid & (occupancy_c < OW'(DEPTH));
    push_c      = inflight_q & ~flush_c;
    pop_c       = inst_valid & inst_ready;
  end

  // Next-state: a redirect flushes everything and kills the returning word.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue_c;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (flush_c) begin
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue_c) begin
        pc_d          = pc_q + XLEN'(1);
        inflight_pc_d = pc_q;
      end
      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     if (halt)  state_q <= HALTED;
        HALTED:  if (!halt) state_q <= RUN;
        default: state_q <= BOOT;
      endcase
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_mem_q[PW'(i)] <= '0;
        pc_mem_q[PW'(i)]   <= '0;
      end
    end else if (push_c) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign imem_req   = issue_c;
  assign imem_addr  = pc_q[IADDR_W-1:0];
  assign inst_valid = (count_q != '0) & ~redirect_valid;
  assign inst       = inst_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign count      = count_q;

  push_not_full_a: assert property (@(posedge clk) disable iff (!reset)
    push_c |-> (count_q < CW'(DEPTH)));

endmodule
